// File: rtl/bram_pkg.sv
// Shared types and helpers for the byte-enable dual-port RAM.
package bram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int MODE_READ_FIRST  = 0;
  localparam int MODE_WRITE_FIRST = 1;

  function automatic int num_bytes(int data_width);
    return data_width / 8;
  endfunction

  // Even parity: stored bit makes the 9-bit lane XOR to zero.
  function automatic logic byte_par(logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/bram_dp_be_if.sv
// Write/read port bundle for bram_dp_be; parity pins exist only with BRAM_PARITY_EN.
interface bram_dp_be_if import bram_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ADD_WIDTH  = 10
);
  localparam int NB = num_bytes(DATA_WIDTH);

  logic                  wr_en;
  logic [ADD_WIDTH-1:0]  wr_add;
  logic [NB-1:0]         wr_be;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [ADD_WIDTH-1:0]  rd_add;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  init_busy;
`ifdef BRAM_PARITY_EN
  logic                  par_inject;
  logic                  par_err;
`endif

  modport master (
    output wr_en, wr_add, wr_be, wr_data, rd_en, rd_add,
`ifdef BRAM_PARITY_EN
    output par_inject, input par_err,
`endif
    input  rd_data, rd_valid, init_busy
  );

  modport slave (
    input  wr_en, wr_add, wr_be, wr_data, rd_en, rd_add,
`ifdef BRAM_PARITY_EN
    input  par_inject, output par_err,
`endif
    output rd_data, rd_valid, init_busy
  );

endinterface

// File: rtl/bram_rd_pipe.sv
// Read-return pipeline: STAGES registers for valid, data and parity error.
module bram_rd_pipe #(
  parameter int W      = 32,
  parameter int STAGES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  input  logic         in_err,
  output logic         out_vld,
  output logic [W-1:0] out_data,
  output logic         out_err
);

  logic [STAGES-1:0]        vld_pipe;
  logic [STAGES-1:0]        err_pipe;
  logic [STAGES-1:0][W-1:0] dat_pipe;

  // Data only advances with a valid beat so the output holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      err_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= in_vld;
      err_pipe[0] <= in_vld & in_err;
      if (in_vld) dat_pipe[0] <= in_data;
      for (int i = 1; i < STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        err_pipe[i] <= err_pipe[i-1];
        if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign out_vld  = vld_pipe[STAGES-1];
  assign out_err  = err_pipe[STAGES-1];
  assign out_data = dat_pipe[STAGES-1];

endmodule

// File: rtl/bram_dp_be.sv
// Simple dual-port RAM with byte enables, post-reset clear sweep and
// configurable read latency. BRAM_PARITY_EN adds per-byte even parity.
module bram_dp_be import bram_pkg::*; #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADD_WIDTH      = 10,
  parameter int READ_LATENCY   = 1,
  parameter int WRITE_FIRST    = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic         clk,
  input logic         rst,
  bram_dp_be_if.slave bus
);

  localparam int NB       = num_bytes(DATA_WIDTH);
  localparam int RAM_SIZE = 2**ADD_WIDTH;
`ifdef BRAM_PARITY_EN
  localparam int LANE_W   = 9;
`else
  localparam int LANE_W   = 8;
`endif

  typedef logic [NB-1:0][LANE_W-1:0] word_t;

  word_t                 mem [RAM_SIZE];
  state_t                state, state_nxt;
  logic [ADD_WIDTH-1:0]  cnt;
  logic                  ready, wr_acc, rd_acc, collide;
  word_t                 wr_word, rd_word;
  logic [DATA_WIDTH-1:0] rd_dat;
  logic                  rd_err, perr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == CLEAR && cnt == '1) state_nxt = READY;
  end

  assign bus.init_busy = (state == CLEAR);
  assign ready   = (state == READY) && !rst;
  assign wr_acc  = ready & bus.wr_en;
  assign rd_acc  = ready & bus.rd_en;
  assign collide = wr_acc && rd_acc && (bus.wr_add == bus.rd_add);

  // wr_word is the full word as it will be stored, so it doubles as the
  // write-first bypass value on a same-address collision.
  always_comb begin
    wr_word = mem[bus.wr_add];
    rd_word = mem[bus.rd_add];
    rd_dat  = '0;
    rd_err  = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (bus.wr_be[i]) begin
`ifdef BRAM_PARITY_EN
        wr_word[i] = {byte_par(bus.wr_data[8*i +: 8]) ^ bus.par_inject,
                      bus.wr_data[8*i +: 8]};
`else
        wr_word[i] = bus.wr_data[8*i +: 8];
`endif
      end
    end
    if (collide && WRITE_FIRST == MODE_WRITE_FIRST) rd_word = wr_word;
    for (int i = 0; i < NB; i++) begin
      rd_dat[8*i +: 8] = rd_word[i][7:0];
`ifdef BRAM_PARITY_EN
      rd_err = rd_err | (rd_word[i][8] ^ byte_par(rd_word[i][7:0]));
`endif
    end
  end

  // Array is never reset; the sweep writes zero (parity of zero is zero).
  always_ff @(posedge clk) begin
    if (state == CLEAR)  mem[cnt]        <= '0;
    else if (wr_acc)     mem[bus.wr_add] <= wr_word;
  end

  bram_rd_pipe #(
    .W      (DATA_WIDTH),
    .STAGES (READ_LATENCY)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (rd_acc),
    .in_data  (rd_dat),
    .in_err   (rd_err),
    .out_vld  (bus.rd_valid),
    .out_data (bus.rd_data),
    .out_err  (perr)
  );

`ifdef BRAM_PARITY_EN
  assign bus.par_err = perr;
`else
  logic unused_perr;
  assign unused_perr = perr;
`endif

endmodule

// File: tb/tb_bram_dp_be.sv
// Scoreboard bench: two instances (latency 1 write-first, latency 2 read-first)
// share one stimulus stream; expected beats are queued when reads are issued.
module tb_bram_dp_be;
  import bram_pkg::*;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int N  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bram_dp_be_if #(.DATA_WIDTH(DW), .ADD_WIDTH(AW)) bus_a ();
  bram_dp_be_if #(.DATA_WIDTH(DW), .ADD_WIDTH(AW)) bus_b ();

  bram_dp_be #(.DATA_WIDTH(DW), .ADD_WIDTH(AW), .READ_LATENCY(1),
               .WRITE_FIRST(1), .CLEAR_ON_RESET(1))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  bram_dp_be #(.DATA_WIDTH(DW), .ADD_WIDTH(AW), .READ_LATENCY(2),
               .WRITE_FIRST(0), .CLEAR_ON_RESET(1))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  typedef struct {
    logic [31:0] data;
    logic        perr;
    int          due;
  } sb_t;

  sb_t         q [2][$];
  int          cyc    = 0;
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] mdl [N];
  logic [3:0]  bad [N];

  logic [1:0]  vld, pe;
  logic [31:0] dat [2];
  assign vld    = {bus_b.rd_valid, bus_a.rd_valid};
  assign dat[0] = bus_a.rd_data;
  assign dat[1] = bus_b.rd_data;
`ifdef BRAM_PARITY_EN
  assign pe = {bus_b.par_err, bus_a.par_err};
`else
  assign pe = 2'b00;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d, logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic drive(bit we, logic [3:0] wa, logic [3:0] be, logic [31:0] wd,
                       bit re, logic [3:0] ra, bit inj);
    bus_a.wr_en = we; bus_a.wr_add = wa; bus_a.wr_be = be; bus_a.wr_data = wd;
    bus_a.rd_en = re; bus_a.rd_add = ra;
    bus_b.wr_en = we; bus_b.wr_add = wa; bus_b.wr_be = be; bus_b.wr_data = wd;
    bus_b.rd_en = re; bus_b.rd_add = ra;
`ifdef BRAM_PARITY_EN
    bus_a.par_inject = inj;
    bus_b.par_inject = inj;
`else
    if (inj) $display("note: parity inject requested without parity build");
`endif
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      mdl[i] = 32'h0;
      bad[i] = 4'h0;
    end
    q[0].delete();
    q[1].delete();
  endtask

  // One accepted cycle: queue expected read beats for both instances, update model.
  task automatic step(bit we, logic [3:0] wa, logic [3:0] be, logic [31:0] wd,
                      bit re, logic [3:0] ra, bit inj);
    sb_t         e;
    logic [31:0] nw;
    logic [3:0]  nb;
    drive(we, wa, be, wd, re, ra, inj);
    nw = merge(mdl[wa], wd, be);
    nb = (bad[wa] & ~be) | (be & {4{inj}});
    if (re) begin
      e.data = (we && wa == ra) ? nw : mdl[ra];
      e.perr = (we && wa == ra) ? |nb : |bad[ra];
      e.due  = cyc + 1;
      q[0].push_back(e);
      e.data = mdl[ra];
      e.perr = |bad[ra];
      e.due  = cyc + 2;
      q[1].push_back(e);
    end
    if (we) begin
      mdl[wa] = nw;
      bad[wa] = nb;
    end
    @(posedge clk); #1;
    idle();
  endtask

  task automatic nop(int n);
    repeat (n) step(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0);
  endtask

  // Counts busy cycles after reset release; optionally hammers address 3 meanwhile.
  task automatic sweep(input bit poke, output int na, output int nb);
    int g;
    na = 0; nb = 0; g = 0;
    if (poke) drive(1'b1, 4'h3, 4'hF, 32'hDEADBEEF, 1'b1, 4'h3, 1'b0);
    while ((bus_a.init_busy || bus_b.init_busy) && g < 100) begin
      if (bus_a.init_busy) na++;
      if (bus_b.init_busy) nb++;
      @(posedge clk); #1;
      g++;
    end
    idle();
  endtask

  always @(negedge clk) begin
    sb_t e;
    for (int k = 0; k < 2; k++) begin
      if (vld[k]) begin
        if (q[k].size() == 0) chk($sformatf("d%0d_spurious_valid", k), 1, 0);
        else begin
          e = q[k].pop_front();
          chk($sformatf("d%0d_data", k), dat[k], e.data);
          chk($sformatf("d%0d_latency", k), cyc, e.due);
`ifdef BRAM_PARITY_EN
          chk($sformatf("d%0d_par_err", k), pe[k], e.perr);
`endif
        end
      end else if (pe[k]) chk($sformatf("d%0d_par_err_idle", k), 1, 0);
      if (q[k].size() > 0 && q[k][0].due < cyc) begin
        chk($sformatf("d%0d_missing_valid", k), 0, 1);
        void'(q[k].pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_chk %0d", n_chk);
    $fatal(1);
  end

  initial begin
    int na, nb;
    idle();
    model_clear();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_a", bus_a.rd_valid, 0);
    chk("rst_valid_b", bus_b.rd_valid, 0);
    chk("rst_data_a", bus_a.rd_data, 0);
    chk("rst_data_b", bus_b.rd_data, 0);
    chk("rst_busy_a", bus_a.init_busy, 1);
    chk("rst_busy_b", bus_b.init_busy, 1);
    rst = 1'b0;

    // Sweep with masked requests to address 3.
    sweep(1'b1, na, nb);
    chk("sweep_len_a", na, 16);
    chk("sweep_len_b", nb, 16);

    // Every word reads zero, streamed back-to-back.
    for (int i = 0; i < N; i++) step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(i), 1'b0);
    nop(3);

    // Byte enables.
    step(1'b1, 4'h5, 4'hF, 32'h11223344, 1'b0, 4'h0, 1'b0);
    step(1'b1, 4'h5, 4'b0101, 32'hAABBCCDD, 1'b0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h5, 1'b0);
    nop(3);

    // Same-address collision, then plain readback.
    step(1'b1, 4'h7, 4'hF, 32'hCAFEF00D, 1'b1, 4'h7, 1'b0);
    step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h7, 1'b0);
    nop(3);

    // Eight writes then eight back-to-back reads.
    for (int i = 8; i < 16; i++) step(1'b1, 4'(i), 4'hF, $urandom, 1'b0, 4'h0, 1'b0);
    for (int i = 8; i < 16; i++) step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(i), 1'b0);
    nop(3);

    // Mixed random traffic on a narrow address range to provoke collisions.
    repeat (150) begin
      bit inj;
`ifdef BRAM_PARITY_EN
      inj = ($urandom_range(0, 7) == 0);
`else
      inj = 1'b0;
`endif
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
           $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), inj);
    end
    nop(3);

    // Asynchronous reset with non-zero read data outstanding on the outputs.
    step(1'b1, 4'hC, 4'hF, 32'h5A5A5A5A, 1'b0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'hC, 1'b0);
    nop(2);
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    chk("async_rst_data_a", bus_a.rd_data, 0);
    chk("async_rst_data_b", bus_b.rd_data, 0);
    chk("async_rst_busy_a", bus_a.init_busy, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Restart the sweep at count 6.
    repeat (6) begin @(posedge clk); #1; end
    chk("mid_busy_a", bus_a.init_busy, 1);
    chk("mid_busy_b", bus_b.init_busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid_a", bus_a.rd_valid, 0);
    chk("mid_rst_data_b", bus_b.rd_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    sweep(1'b0, na, nb);
    chk("resweep_len_a", na, 16);
    chk("resweep_len_b", nb, 16);
    step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'hC, 1'b0);
    step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h5, 1'b0);
    nop(3);

`ifdef BRAM_PARITY_EN
    step(1'b1, 4'h2, 4'hF, 32'h12345678, 1'b0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h2, 1'b0);
    step(1'b1, 4'h2, 4'hF, 32'h12345678, 1'b0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h2, 1'b0);
    nop(3);
`endif

    nop(4);
    chk("drain_a", q[0].size(), 0);
    chk("drain_b", q[1].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_dp_be.md
Name: bram_dp_be

Overview:
- Parametrised simple-dual-port block RAM: one write port with byte enables, one independent read port.
- Read latency is configurable; a valid flag is aligned with the read data.
- Defined read-during-write collision behaviour.
- Optional post-reset hardware clear sweep that zeroes every word before the RAM accepts traffic.
- Generic on-chip buffer for the BDPU datapath (weights, activations, scratch).

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADD_WIDTH, 10, address width; depth RAM_SIZE = 2**ADD_WIDTH.
- READ_LATENCY, 1, cycles from rd_en sample to rd_data/rd_valid; legal values 1 or 2.
- WRITE_FIRST, 1, collision mode: 1 returns newly written data, 0 returns old data.
- CLEAR_ON_RESET, 1, 1 = zero all words after reset, 0 = skip the sweep.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset; asynchronous, active-high.
- wr_en  in  1  write request.
- wr_add  in  ADD_WIDTH  write address.
- wr_be  in  DATA_WIDTH/8  byte enables; bit i covers data[8i+7:8i].
- wr_data  in  DATA_WIDTH  write data.
- rd_en  in  1  read request.
- rd_add  in  ADD_WIDTH  read address.
- rd_data  out  DATA_WIDTH  read data; registered.
- rd_valid  out  1  high for exactly one cycle per accepted read, aligned with rd_data.
- init_busy  out  1  high while the clear sweep runs; requests are ignored while high.
- par_err  out  1  (BRAM_PARITY_EN only) parity mismatch on the current rd_valid beat.
- par_inject  in  1  (BRAM_PARITY_EN only) corrupt stored parity on this write.

Behaviour:
- Reset, asynchronous: rd_data=0, rd_valid=0, par_err=0, read pipeline flushed, clear counter=0.
  - FSM goes to CLEAR if CLEAR_ON_RESET=1, else READY.
  - init_busy=CLEAR_ON_RESET.
  - The memory array itself is not reset.
- FSM states: CLEAR, READY.
  - CLEAR: each cycle writes 0 (and correct parity) to address cnt, then cnt++. After cnt=RAM_SIZE-1 is written, the next state is READY and init_busy drops on that edge. The sweep takes exactly RAM_SIZE cycles.
  - READY: normal operation; stays in READY until rst.
- Requests during CLEAR: wr_en and rd_en are ignored; no memory change from the user port; rd_valid stays 0.
- Reset mid-sweep: the sweep restarts from address 0.
- Write (READY): when wr_en=1, at posedge each byte i with wr_be[i]=1 is updated; other bytes keep their value. wr_en=1 with wr_be=0 is a no-op.
- Read (READY): rd_en sampled at edge N.
  - rd_data and rd_valid appear after edge N+READ_LATENCY-1 (visible in cycle N+READ_LATENCY).
  - Back-to-back reads are accepted every cycle; full throughput.
- rd_data holds its last value when no read completes. rd_valid is a single-cycle pulse per read.
- Collision (rd_en and wr_en in the same cycle, same address):
  - WRITE_FIRST=1: returned word = old word with enabled bytes replaced by wr_data.
  - WRITE_FIRST=0: returned word = pre-write contents.
  - Different addresses: no interaction.
- Address width is exact; all addresses are in range. No wrap logic is needed beyond the counter terminating at RAM_SIZE-1.

Optional Feature:
- Macro: BRAM_PARITY_EN.
- Defined:
  - Each byte is stored with one even-parity bit; the array is DATA_WIDTH + DATA_WIDTH/8 bits wide.
  - Parity is recomputed on read; par_err=1 alongside rd_valid if any enabled-byte parity mismatches.
  - par_inject=1 on a write inverts the stored parity of the written bytes.
  - par_err resets to 0 and is 0 whenever rd_valid=0.
- Not defined: no parity bits, and no par_err or par_inject ports.

Decomposition:
- Package bram_pkg holds:
  - FSM state typedef (CLEAR, READY).
  - Collision-mode constants (MODE_READ_FIRST=0, MODE_WRITE_FIRST=1).
  - Byte-parity function.
  - Localparam helper for NUM_BYTES = DATA_WIDTH/8.
- One sub-module, bram_rd_pipe: READ_LATENCY-deep register pipeline for data, valid and parity-error, with async reset to 0.

Test Plan:
- Clear sweep: rst pulse, ADD_WIDTH=4, CLEAR_ON_RESET=1 -> init_busy high exactly 16 cycles; reading all 16 addresses afterwards returns 0x00000000.
- Clear mask: wr_en/rd_en asserted during CLEAR with wr_add=3, data 0xDEADBEEF -> no rd_valid; address 3 reads 0 after READY.
- Byte enables: write 0x11223344 be=1111 at addr 5, then 0xAABBCCDD be=0101 -> read returns 0x11BB33DD; rd_valid exactly READ_LATENCY cycles after rd_en (check both latencies).
- Collision: addr 7 holds 0x00000000; same-cycle write 0xCAFEF00D be=1111 and read addr 7 -> 0xCAFEF00D with WRITE_FIRST=1, 0x00000000 with WRITE_FIRST=0.
- Streaming and mid-sweep reset: 8 back-to-back reads -> 8 consecutive rd_valid pulses in order. rst asserted at sweep count 6 -> outputs 0 immediately, sweep restarts and lasts the full 16 cycles.
- Parity (BRAM_PARITY_EN): write addr 2 with par_inject=1 -> read addr 2 gives par_err=1 with rd_valid; a rewrite without inject then read -> par_err=0.
